// File: rtl/frame_bank_scheduler.sv
// Ping-pong ownership controller for two frame SRAM banks: receiver writes one bank
// while the scan engine bursts whole frames out of the other, dropping frames it cannot keep.
module frame_bank_scheduler #(
  parameter int AW          = 9,
  parameter int FRAME_WORDS = 512
) (
  input  logic          DCK,
  input  logic          rst,
  input  logic          wr_strobe,
  output logic          wr_en1,
  output logic          wr_en2,
  output logic [AW-1:0] wr_addr,
  output logic          wr_bank,
  input  logic          rd_start,
  output logic          rd_cen1,
  output logic          rd_cen2,
  output logic [AW-1:0] rd_addr,
  output logic          rd_valid,
  output logic          rd_last,
  output logic          rd_busy,
  output logic          frame_ready,
  output logic          frame_drop,
  output logic          rd_nodata
);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_READING
  } bank_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_READ,
    RD_DRAIN
  } rd_state_t;

  localparam logic [AW-1:0] LAST_WORD = AW'(FRAME_WORDS - 1);

  bank_state_t   bank_reg  [2];
  bank_state_t   bank_next [2];
  logic          wr_bank_reg, wr_bank_next;
  logic [AW-1:0] wcnt_reg, wcnt_next;
  logic [AW-1:0] wr_addr_reg;
  logic [1:0]    wr_en_n_reg;
  logic          frame_drop_reg, frame_drop_next;

  rd_state_t     rd_state_reg, rd_state_next;
  logic          rd_sel_reg, rd_sel_next;
  logic [AW-1:0] rcnt_reg, rcnt_next;
  logic          rd_valid_reg, rd_last_reg;
  logic          rd_nodata_reg, rd_nodata_next;

  logic          full_any;
  logic          full_sel;
  logic          grant;
  logic          wr_done;
  logic          other_bank;
  logic          other_busy;

  assign full_any   = (bank_reg[0] == BANK_FULL) || (bank_reg[1] == BANK_FULL);
  assign full_sel   = (bank_reg[1] == BANK_FULL);
  assign grant      = (rd_state_reg == RD_IDLE) && rd_start && full_any;
  assign wr_done    = wr_strobe && (wcnt_reg == LAST_WORD);
  assign other_bank = ~wr_bank_reg;
  // A FULL bank can only be the non-write bank, so a grant this edge claims it for the reader;
  // the reader keeps that frame and the just-completed one is the one discarded.
  assign other_busy = (bank_reg[other_bank] == BANK_READING) || grant;

  always_comb begin
    bank_next[0]    = bank_reg[0];
    bank_next[1]    = bank_reg[1];
    wr_bank_next    = wr_bank_reg;
    wcnt_next       = wcnt_reg;
    frame_drop_next = 1'b0;
    if (wr_strobe) begin
      if (wr_done) begin
        wcnt_next = '0;
        if (other_busy) begin
          bank_next[wr_bank_reg] = BANK_EMPTY;
          frame_drop_next        = 1'b1;
        end else begin
          bank_next[wr_bank_reg] = BANK_FULL;
          wr_bank_next           = other_bank;
          if (bank_reg[other_bank] == BANK_FULL) begin
            bank_next[other_bank] = BANK_EMPTY;
            frame_drop_next       = 1'b1;
          end
        end
      end else begin
        wcnt_next              = wcnt_reg + 1'b1;
        bank_next[wr_bank_reg] = BANK_FILLING;
      end
    end
    if (grant) begin
      bank_next[full_sel] = BANK_READING;
    end
    if (rd_state_reg == RD_DRAIN) begin
      bank_next[rd_sel_reg] = BANK_EMPTY;
    end
  end

  always_comb begin
    rd_state_next  = rd_state_reg;
    rd_sel_next    = rd_sel_reg;
    rcnt_next      = rcnt_reg;
    rd_nodata_next = 1'b0;
    case (rd_state_reg)
      RD_IDLE: begin
        if (rd_start) begin
          if (full_any) begin
            rd_state_next = RD_READ;
            rd_sel_next   = full_sel;
            rcnt_next     = '0;
          end else begin
            rd_nodata_next = 1'b1;
          end
        end
      end
      RD_READ: begin
        if (rcnt_reg == LAST_WORD) begin
          rd_state_next = RD_DRAIN;
          rcnt_next     = '0;
        end else begin
          rcnt_next = rcnt_reg + 1'b1;
        end
      end
      RD_DRAIN: begin
        rd_state_next = RD_IDLE;
      end
      default: begin
        rd_state_next = RD_IDLE;
      end
    endcase
  end

  always_ff @(posedge DCK) begin
    if (rst) begin
      bank_reg[0]    <= BANK_EMPTY;
      bank_reg[1]    <= BANK_EMPTY;
      wr_bank_reg    <= 1'b0;
      wcnt_reg       <= '0;
      wr_addr_reg    <= '0;
      wr_en_n_reg    <= 2'b11;
      frame_drop_reg <= 1'b0;
      rd_state_reg   <= RD_IDLE;
      rd_sel_reg     <= 1'b0;
      rcnt_reg       <= '0;
      rd_valid_reg   <= 1'b0;
      rd_last_reg    <= 1'b0;
      rd_nodata_reg  <= 1'b0;
    end else begin
      bank_reg[0]    <= bank_next[0];
      bank_reg[1]    <= bank_next[1];
      wr_bank_reg    <= wr_bank_next;
      wcnt_reg       <= wcnt_next;
      if (wr_strobe) begin
        wr_addr_reg <= wcnt_reg;
      end
      wr_en_n_reg    <= {~(wr_strobe && wr_bank_reg), ~(wr_strobe && !wr_bank_reg)};
      frame_drop_reg <= frame_drop_next;
      rd_state_reg   <= rd_state_next;
      rd_sel_reg     <= rd_sel_next;
      rcnt_reg       <= rcnt_next;
      // SRAM has one cycle of read latency, so valid/last trail the chip enable.
      rd_valid_reg   <= (rd_state_reg == RD_READ);
      rd_last_reg    <= (rd_state_reg == RD_READ) && (rcnt_reg == LAST_WORD);
      rd_nodata_reg  <= rd_nodata_next;
    end
  end

  assign wr_en1      = wr_en_n_reg[0];
  assign wr_en2      = wr_en_n_reg[1];
  assign wr_addr     = wr_addr_reg;
  assign wr_bank     = wr_bank_reg;
  assign rd_cen1     = ~((rd_state_reg == RD_READ) && !rd_sel_reg);
  assign rd_cen2     = ~((rd_state_reg == RD_READ) && rd_sel_reg);
  assign rd_addr     = rcnt_reg;
  assign rd_valid    = rd_valid_reg;
  assign rd_last     = rd_last_reg;
  assign rd_busy     = (rd_state_reg != RD_IDLE);
  assign frame_ready = full_any;
  assign frame_drop  = frame_drop_reg;
  assign rd_nodata   = rd_nodata_reg;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Directed and randomized bench for frame_bank_scheduler; outputs are compared every cycle
// against a frame/burst-level reference model of bank ownership.
module tb_frame_bank_scheduler;

  localparam int AW = 9;
  localparam int FW = 512;

  localparam int EMPTY   = 0;
  localparam int FILLING = 1;
  localparam int FULL    = 2;
  localparam int READING = 3;

  logic          DCK = 1'b0;
  logic          rst = 1'b1;
  logic          wr_strobe = 1'b0;
  logic          rd_start = 1'b0;
  logic          wr_en1, wr_en2, wr_bank;
  logic [AW-1:0] wr_addr;
  logic          rd_cen1, rd_cen2;
  logic [AW-1:0] rd_addr;
  logic          rd_valid, rd_last, rd_busy;
  logic          frame_ready, frame_drop, rd_nodata;

  frame_bank_scheduler #(.AW(AW), .FRAME_WORDS(FW)) dut (
    .DCK(DCK),
    .rst(rst),
    .wr_strobe(wr_strobe),
    .wr_en1(wr_en1),
    .wr_en2(wr_en2),
    .wr_addr(wr_addr),
    .wr_bank(wr_bank),
    .rd_start(rd_start),
    .rd_cen1(rd_cen1),
    .rd_cen2(rd_cen2),
    .rd_addr(rd_addr),
    .rd_valid(rd_valid),
    .rd_last(rd_last),
    .rd_busy(rd_busy),
    .frame_ready(frame_ready),
    .frame_drop(frame_drop),
    .rd_nodata(rd_nodata)
  );

  always #5 DCK = ~DCK;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: bank ownership, write word index, burst position (-1 idle, FW = drain).
  int m_bank [2];
  int m_wbank, m_wcnt, m_rd_pos, m_rd_bank;
  int m_just_reset;
  int e_en1, e_en2, e_waddr, e_valid, e_last, e_drop, e_nodata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit ws, input bit rs);
    int pre [2];
    int full_idx;
    int other;
    bit grant;
    m_just_reset = 0;
    if (r) begin
      m_bank[0] = EMPTY; m_bank[1] = EMPTY;
      m_wbank = 0; m_wcnt = 0; m_rd_pos = -1; m_rd_bank = 0;
      e_en1 = 1; e_en2 = 1; e_waddr = 0;
      e_valid = 0; e_last = 0; e_drop = 0; e_nodata = 0;
      m_just_reset = 1;
      return;
    end
    pre[0] = m_bank[0];
    pre[1] = m_bank[1];
    e_valid = (m_rd_pos >= 0 && m_rd_pos < FW) ? 1 : 0;
    e_last  = (m_rd_pos == FW - 1) ? 1 : 0;
    e_en1   = (ws && m_wbank == 0) ? 0 : 1;
    e_en2   = (ws && m_wbank == 1) ? 0 : 1;
    if (ws) e_waddr = m_wcnt;
    e_drop = 0;
    e_nodata = 0;
    full_idx = -1;
    for (int b = 0; b < 2; b++) if (pre[b] == FULL) full_idx = b;
    grant = (m_rd_pos < 0) && rs && (full_idx >= 0);

    if (m_rd_pos < 0) begin
      if (rs) begin
        if (grant) begin
          m_rd_bank = full_idx;
          m_bank[full_idx] = READING;
          m_rd_pos = 0;
          $display("t=%0t burst start from bank%0d", $time, full_idx + 1);
        end else begin
          e_nodata = 1;
          $display("t=%0t rd_start with no frame", $time);
        end
      end
    end else if (m_rd_pos < FW) begin
      m_rd_pos++;
    end else begin
      m_bank[m_rd_bank] = EMPTY;
      m_rd_pos = -1;
      $display("t=%0t burst done, bank%0d released", $time, m_rd_bank + 1);
    end

    if (ws) begin
      if (m_wcnt == FW - 1) begin
        m_wcnt = 0;
        other = 1 - m_wbank;
        if (pre[other] == READING || grant) begin
          m_bank[m_wbank] = EMPTY;
          e_drop = 1;
          $display("t=%0t frame in bank%0d discarded (reader busy)", $time, m_wbank + 1);
        end else begin
          m_bank[m_wbank] = FULL;
          if (pre[other] == FULL) begin
            m_bank[other] = EMPTY;
            e_drop = 1;
          end
          $display("t=%0t frame complete in bank%0d, older frame dropped=%0d", $time, m_wbank + 1, e_drop);
          m_wbank = other;
        end
      end else begin
        m_wcnt++;
        m_bank[m_wbank] = FILLING;
      end
    end
  endtask

  task automatic compare();
    int reading;
    reading = (m_rd_pos >= 0 && m_rd_pos < FW) ? 1 : 0;
    check("wr_en1", 32'(wr_en1), e_en1);
    check("wr_en2", 32'(wr_en2), e_en2);
    if (e_en1 == 0 || e_en2 == 0 || m_just_reset != 0) check("wr_addr", 32'(wr_addr), e_waddr);
    check("wr_bank", 32'(wr_bank), m_wbank);
    check("rd_cen1", 32'(rd_cen1), (reading != 0 && m_rd_bank == 0) ? 0 : 1);
    check("rd_cen2", 32'(rd_cen2), (reading != 0 && m_rd_bank == 1) ? 0 : 1);
    if (reading != 0 || m_just_reset != 0) check("rd_addr", 32'(rd_addr), (reading != 0) ? m_rd_pos : 0);
    check("rd_valid", 32'(rd_valid), e_valid);
    check("rd_last", 32'(rd_last), e_last);
    check("rd_busy", 32'(rd_busy), (m_rd_pos >= 0) ? 1 : 0);
    check("frame_ready", 32'(frame_ready), (m_bank[0] == FULL || m_bank[1] == FULL) ? 1 : 0);
    check("frame_drop", 32'(frame_drop), e_drop);
    check("rd_nodata", 32'(rd_nodata), e_nodata);
  endtask

  task automatic cycle(input bit r, input bit ws, input bit rs);
    rst = r;
    wr_strobe = ws;
    rd_start = rs;
    @(posedge DCK);
    model_step(r, ws, rs);
    @(negedge DCK);
    compare();
  endtask

  initial begin
    bit r, ws, rs;
    // reset state
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    $display("step: fill first frame");
    repeat (FW) cycle(0, 1, 0);
    cycle(0, 0, 0);
    $display("step: read first frame");
    cycle(0, 0, 1);
    repeat (FW + 4) cycle(0, 0, 0);
    $display("step: rd_start right after reset");
    cycle(1, 0, 0);
    cycle(0, 0, 1);
    repeat (3) cycle(0, 0, 0);
    $display("step: three frames without reads");
    cycle(1, 0, 0);
    repeat (3 * FW) cycle(0, 1, 0);
    cycle(0, 0, 1);
    repeat (FW + 4) cycle(0, 0, 0);
    $display("step: frames completing during a burst");
    cycle(1, 0, 0);
    repeat (FW) cycle(0, 1, 0);
    cycle(0, 1, 1);
    repeat (2 * FW) cycle(0, 1, 0);
    repeat (FW + 4) cycle(0, 0, 0);
    $display("step: completion coincident with rd_start");
    cycle(1, 0, 0);
    repeat (FW - 1) cycle(0, 1, 0);
    cycle(0, 1, 1);
    repeat (FW - 1) cycle(0, 1, 0);
    cycle(0, 1, 1);
    repeat (FW + 4) cycle(0, 0, 0);
    $display("step: reset at burst word 100");
    cycle(1, 0, 0);
    repeat (FW) cycle(0, 1, 0);
    cycle(0, 0, 1);
    repeat (100) cycle(0, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 1);
    repeat (2) cycle(0, 0, 0);
    $display("step: randomized traffic");
    cycle(1, 0, 0);
    repeat (6000) begin
      r  = ($urandom_range(0, 2999) == 0);
      ws = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 99) == 0);
      cycle(r, ws, rs);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
